// File: rtl/downsizer_rr_arb.sv
// Round-robin arbiter sharing one wide-to-narrow downsizer between NUM_REQ requesters.
// Issues one wide word per grant and tags each narrow beat with its source ID and last flag.
module downsizer_rr_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned INP_DATA_WIDTH = 128,
  parameter int unsigned DATA_OUT_WIDTH = 32,
  parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*INP_DATA_WIDTH*8-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            ds_ready,
  input  logic                            ds_out_en,
  output logic                            ds_valid_in,
  output logic [INP_DATA_WIDTH*8-1:0]     ds_inp_data,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            out_last,
  output logic                            busy,
  output logic                            err_proto
);

  localparam int unsigned RATIO = INP_DATA_WIDTH / DATA_OUT_WIDTH;
  localparam int unsigned WW    = INP_DATA_WIDTH * 8;
  localparam int unsigned BCW   = $clog2(RATIO) + 1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  elig;
  logic                gnt_vld;
  logic [ID_WIDTH-1:0] gnt_id;

  assign elig      = req_valid & req_en;
  assign busy      = (state_q == S_ACTIVE);
  assign err_proto = err_q;

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [ID_WIDTH-1:0] cand;
      cand = ID_WIDTH'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    req_ready   = '0;
    ds_valid_in = 1'b0;
    ds_inp_data = '0;
    out_id      = '0;
    out_last    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ds_ready && gnt_vld) begin
          req_ready[gnt_id] = 1'b1;
          ds_valid_in       = 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == gnt_id) ds_inp_data = req_data[i*WW +: WW];
          end
          // Downsizer accepts with zero latency, so the first beat appears now
          if (ds_out_en) out_id = gnt_id;
          else           err_d  = 1'b1;
          cur_id_d   = gnt_id;
          beat_cnt_d = BCW'(1);
          state_d    = S_ACTIVE;
          rr_ptr_d   = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_WIDTH'(1);
        end else if (ds_out_en) begin
          err_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ds_out_en) begin
          out_id = cur_id_q;
          if (32'(beat_cnt_q) == RATIO - 1) begin
            out_last   = 1'b1;
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
